sub_bytes_seq: RTL
==================

Name: sub_bytes_seq

Overview:
- Sequential forward SubBytes engine for the AES encryption datapath; the encryption-side counterpart of the decryption byte-substitution stage.
- Accepts one 128-bit state per transaction over a valid/ready handshake.
- Substitutes the 16 bytes through BYTES_PER_CYCLE shared sbox instances over several cycles, trading area for latency.
- Returns the substituted state over a second valid/ready handshake to the round controller.

Parameters:
BYTES_PER_CYCLE, 4, number of sbox instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data holds a state to be substituted.
in_ready  output  1  block can accept a new state.
in_data  input  [0:127]  AES state; byte k occupies bits [8k +: 8], so byte 0 is bits 0..7.
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  downstream accepts the result.
out_data  output  [0:127]  substituted state, same byte ordering as in_data.

Behaviour:
- Reset values (asynchronous on rst high): state=IDLE, in_ready=1, out_valid=0, out_data=0, byte counter=0, working register=0.
- Define N = 16/BYTES_PER_CYCLE as the number of substitution passes.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture in_data into the working register, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, replace bytes [c*BPC .. c*BPC+BPC-1] of the working register with their sbox outputs, then increment c.
  - After the pass with c=N-1, go to DONE.
- DONE:
  - out_valid=1; out_data is driven from the working register and is held stable while out_valid && !out_ready.
  - On out_ready, clear out_valid and return to IDLE.
- Latency: handshake accept at edge T gives out_valid=1 after edge T+N (N=4 by default). Peak throughput is one state per N+2 cycles.
- No overlap:
  - in_ready is low in BUSY and DONE.
  - in_valid asserted during BUSY/DONE is ignored, and in_data is not sampled.
  - The upstream side must hold in_valid until accepted.
- out_ready asserted while not in DONE has no effect.
- Reset asserted mid-operation aborts the transaction with no partial output; the block returns to reset values immediately.
- sbox is the team's combinational forward S-box (8-bit in, 8-bit out), instantiated BYTES_PER_CYCLE times. Counter width is clog2(N), minimum 1.
- With BYTES_PER_CYCLE=16, N=1: a single BUSY cycle.
- An illegal parameter value triggers an elaboration-time error.

Optional Feature:
- Macro SUB_BYTES_INV_EN.
- Defined:
  - Adds port inv_sel (input, 1): 0 selects forward SubBytes, 1 selects InvSubBytes.
  - inv_sel is captured together with in_data on accept.
  - BYTES_PER_CYCLE inv_sbox instances are added, and per-byte muxes select between sbox and inv_sbox outputs using the captured inv_sel.
  - The block then serves both the encryption and decryption rounds.
- Not defined: no inv_sel port and no inv_sbox instances; the block is forward-only.

Test Plan:
- Reset, then in_data=all 0x00, in_valid=1 for one cycle -> out_valid rises exactly 4 cycles after accept; out_data=0x6363...63 (16 bytes).
- in_data=193de3bea0f4e22b9ac68d2ae9f84808 (FIPS-197 App. B round 1) -> out_data=d42711aee0bf98f1b8b45de51e415230.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; in_valid with new data is ignored. Then out_ready=1 -> out_valid=0, in_ready=1 next cycle.
- Assert rst for 1 cycle during BUSY at c=2 -> all outputs return to reset values asynchronously; the next transaction (all 0x52) yields out_data=all 0x00 with normal latency.
- Re-run the FIPS vector with BYTES_PER_CYCLE=1 and 16 -> same results, with latency 16 and 1 respectively.
- With SUB_BYTES_INV_EN defined: inv_sel=1, in_data=all 0x63 -> out_data=all 0x00; then a back-to-back inv_sel=0 transaction -> out_data=all 0x63.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes engine sharing BYTES_PER_CYCLE S-boxes over 16/BPC passes.
// Define SUB_BYTES_INV_EN to add an inv_sel port and InvSubBytes support.
package sub_bytes_pkg;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b} << n;
      return w[15:8];
   endfunction

endpackage

module sbox
   import sub_bytes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   logic [7:0] b;
   assign b   = gf_inv(a_i);
   assign y_o = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
endmodule

`ifdef SUB_BYTES_INV_EN
module inv_sbox
   import sub_bytes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   logic [7:0] b;
   assign b   = rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05;
   assign y_o = gf_inv(b);
endmodule
`endif

module sub_bytes_seq #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
`ifdef SUB_BYTES_INV_EN
   input  logic         inv_sel,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data
);

   localparam int N  = 16 / BYTES_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 &&
       BYTES_PER_CYCLE != 4 && BYTES_PER_CYCLE != 8 &&
       BYTES_PER_CYCLE != 16) begin : g_bad_param
      $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [0:127]    work_q, work_d;
   logic [7:0]      sb_in  [BYTES_PER_CYCLE];
   logic [7:0]      fwd    [BYTES_PER_CYCLE];
   logic [7:0]      sub    [BYTES_PER_CYCLE];
`ifdef SUB_BYTES_INV_EN
   logic            inv_q, inv_d;
   logic [7:0]      bwd    [BYTES_PER_CYCLE];
`endif

   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      assign sb_in[j] = work_q[(int'(cnt_q) * BYTES_PER_CYCLE + j) * 8 +: 8];
      sbox u_sbox (.a_i(sb_in[j]), .y_o(fwd[j]));
`ifdef SUB_BYTES_INV_EN
      inv_sbox u_inv_sbox (.a_i(sb_in[j]), .y_o(bwd[j]));
      assign sub[j] = inv_q ? bwd[j] : fwd[j];
`else
      assign sub[j] = fwd[j];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
`ifdef SUB_BYTES_INV_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
`ifdef SUB_BYTES_INV_EN
         inv_q   <= inv_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
`ifdef SUB_BYTES_INV_EN
      inv_d   = inv_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               cnt_d   = '0;
               state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
               inv_d   = inv_sel;
`endif
            end
         end
         BUSY: begin
            for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
               work_d[(int'(cnt_q) * BYTES_PER_CYCLE + j) * 8 +: 8] = sub[j];
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = work_q;

endmodule
